// File: rtl/led_session_controller.sv
// Button front-end and session sequencer for the LED pattern engine.
// Debounced start/stop/mode presses drive an IDLE/CLEAR/RUN/DONE session.
module led_session_controller #(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int TICK_DIV   = 100_000_000,
  parameter int RUN_SECS   = 30,
  parameter int DONE_SECS  = 3,
  parameter int CLR_CYCLES = 4_194_304
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_mode,
  output logic [1:0] mode,
  output logic       start,
  output logic       idle,
  output logic       mini_rst,
  output logic       busy,
  output logic [7:0] sec_left
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(CLR_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [7:0]     RUN_LOAD  = 8'(RUN_SECS);
  localparam logic [7:0]     DONE_LOAD = 8'(DONE_SECS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  // Bit order in all button vectors: [0]=start, [1]=stop, [2]=mode
  logic [2:0]     r_sync0;
  logic [2:0]     r_sync1;
  logic [2:0]     r_db_lvl;
  logic [2:0]     r_db_q;
  logic [2:0]     r_evt;
  logic [DBW-1:0] r_db_cnt [3];

  state_t         r_state;
  logic [1:0]     r_mode;
  logic           r_start;
  logic           r_idle;
  logic           r_mini_rst;
  logic           r_busy;
  logic [7:0]     r_sec_left;
  logic [7:0]     r_hold;
  logic [TW-1:0]  r_tick_cnt;
  logic [CW-1:0]  r_clr_cnt;

  logic           w_start_ev;
  logic           w_stop_ev;
  logic           w_mode_ev;
  logic           w_tick;
  logic [1:0]     w_mode_nxt;

  assign w_start_ev = r_evt[0];
  assign w_stop_ev  = r_evt[1];
  assign w_mode_ev  = r_evt[2];
  assign w_tick     = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync0  <= '0;
      r_sync1  <= '0;
      r_db_lvl <= '0;
      r_db_q   <= '0;
      r_evt    <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync0 <= {btn_mode, btn_stop, btn_start};
      r_sync1 <= r_sync0;
      r_db_q  <= r_db_lvl;
      r_evt   <= r_db_lvl & ~r_db_q;
      for (int i = 0; i < 3; i++) begin
        if (r_sync1[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_lvl[i] <= r_sync1[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    w_mode_nxt = 2'b10;
    unique case (r_mode)
      2'b01:   w_mode_nxt = 2'b10;
      2'b10:   w_mode_nxt = 2'b11;
      2'b11:   w_mode_nxt = 2'b01;
      default: w_mode_nxt = 2'b10;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'b10;
      r_start    <= 1'b0;
      r_idle     <= 1'b1;
      r_mini_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_sec_left <= '0;
      r_hold     <= '0;
      r_tick_cnt <= '0;
      r_clr_cnt  <= '0;
    end else begin
      // Tick counter idles at 0; RUN/DONE hold branches reload it below
      r_tick_cnt <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mode_ev) r_mode <= w_mode_nxt;
          if (w_start_ev) begin
            r_state    <= S_CLEAR;
            r_idle     <= 1'b0;
            r_mini_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_clr_cnt  <= '0;
          end
        end
        S_CLEAR: begin
          if (w_stop_ev) begin
            r_state    <= S_IDLE;
            r_idle     <= 1'b1;
            r_mini_rst <= 1'b0;
            r_busy     <= 1'b0;
          end else if (r_clr_cnt == CLR_LAST) begin
            r_state    <= S_RUN;
            r_mini_rst <= 1'b0;
            r_start    <= 1'b1;
            r_sec_left <= RUN_LOAD;
          end else begin
            r_clr_cnt <= r_clr_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (w_stop_ev) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_idle     <= 1'b1;
            r_busy     <= 1'b0;
            r_sec_left <= '0;
          end else if (w_tick && r_sec_left <= 8'd1) begin
            r_state    <= S_DONE;
            r_start    <= 1'b0;
            r_sec_left <= '0;
            r_hold     <= DONE_LOAD;
          end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick) r_sec_left <= r_sec_left - 8'd1;
          end
        end
        S_DONE: begin
          if (w_stop_ev) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_start_ev) begin
            r_state    <= S_CLEAR;
            r_mini_rst <= 1'b1;
            r_clr_cnt  <= '0;
          end else if (w_tick && r_hold <= 8'd1) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (w_tick) r_hold <= r_hold - 8'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_start    <= 1'b0;
          r_idle     <= 1'b1;
          r_mini_rst <= 1'b0;
          r_busy     <= 1'b0;
          r_sec_left <= '0;
        end
      endcase
    end
  end

  assign mode     = r_mode;
  assign start    = r_start;
  assign idle     = r_idle;
  assign mini_rst = r_mini_rst;
  assign busy     = r_busy;
  assign sec_left = r_sec_left;

endmodule

// File: tb/tb_led_session_controller.sv
// Directed bench for led_session_controller with small timing parameters.
// Status nibble is {idle,start,mini_rst,busy}.
module tb_led_session_controller;

  logic       sys_clk;
  logic       sys_rst;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_mode;
  logic [1:0] mode;
  logic       start;
  logic       idle;
  logic       mini_rst;
  logic       busy;
  logic [7:0] sec_left;
  logic [3:0] st;

  int n_chk;
  int n_err;

  localparam logic [3:0] ST_IDLE  = 4'b1000;
  localparam logic [3:0] ST_CLEAR = 4'b0011;
  localparam logic [3:0] ST_RUN   = 4'b0101;
  localparam logic [3:0] ST_DONE  = 4'b0001;

  led_session_controller #(
    .DB_CYCLES (4),
    .TICK_DIV  (10),
    .RUN_SECS  (3),
    .DONE_SECS (2),
    .CLR_CYCLES(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .btn_start(btn_start),
    .btn_stop (btn_stop),
    .btn_mode (btn_mode),
    .mode     (mode),
    .start    (start),
    .idle     (idle),
    .mini_rst (mini_rst),
    .busy     (busy),
    .sec_left (sec_left)
  );

  assign st = {idle, start, mini_rst, busy};

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] mode_exp [3];
  int early;

  initial begin
    n_chk = 0;
    n_err = 0;
    early = 0;
    mode_exp[0] = 2'b11;
    mode_exp[1] = 2'b01;
    mode_exp[2] = 2'b10;
    sys_rst   = 1'b1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_mode  = 1'b0;
    step(3);
    chk("rst_mode", 32'(mode), 32'd2);
    chk("rst_st", 32'(st), 32'(ST_IDLE));
    chk("rst_sec", 32'(sec_left), 32'd0);
    sys_rst = 1'b0;
    step(2);

    // Bounce: 2-cycle chunks high/low, then stable high
    for (int i = 0; i < 10; i++) begin
      btn_start = (i % 2 == 0);
      repeat (2) begin
        step(1);
        if (st != ST_IDLE) early++;
      end
    end
    chk("bnc_quiet", 32'(early), 32'd0);
    btn_start = 1'b1;
    step(2);
    btn_stop = 1'b1;
    step(5);
    chk("bnc_pre", 32'(st), 32'(ST_IDLE));
    step(1);
    chk("bnc_clr", 32'(st), 32'(ST_CLEAR));
    step(1);
    chk("clr_hold", 32'(st), 32'(ST_CLEAR));
    step(1);
    chk("clr_stop", 32'(st), 32'(ST_IDLE));
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    step(10);

    // Full session
    btn_start = 1'b1;
    step(8);
    chk("ses_clr", 32'(st), 32'(ST_CLEAR));
    btn_start = 1'b0;
    step(4);
    chk("ses_clr5", 32'(st), 32'(ST_CLEAR));
    step(1);
    chk("ses_run", 32'(st), 32'(ST_RUN));
    chk("ses_s3", 32'(sec_left), 32'd3);
    step(9);
    chk("ses_s3b", 32'(sec_left), 32'd3);
    step(1);
    chk("ses_s2", 32'(sec_left), 32'd2);
    step(10);
    chk("ses_s1", 32'(sec_left), 32'd1);
    step(9);
    chk("ses_run_end", 32'(st), 32'(ST_RUN));
    step(1);
    chk("ses_done", 32'(st), 32'(ST_DONE));
    chk("ses_s0", 32'(sec_left), 32'd0);
    step(19);
    chk("ses_done_end", 32'(st), 32'(ST_DONE));
    step(1);
    chk("ses_idle", 32'(st), 32'(ST_IDLE));
    step(5);

    // Mode cycling in IDLE
    for (int i = 0; i < 3; i++) begin
      btn_mode = 1'b1;
      step(8);
      chk("mode_cyc", 32'(mode), 32'(mode_exp[i]));
      btn_mode = 1'b0;
      step(10);
    end

    // Mode press during RUN, then start+stop together
    btn_start = 1'b1;
    step(8);
    btn_start = 1'b0;
    step(5);
    chk("mr_run", 32'(st), 32'(ST_RUN));
    btn_mode = 1'b1;
    step(8);
    chk("mr_mode", 32'(mode), 32'd2);
    chk("mr_st", 32'(st), 32'(ST_RUN));
    btn_mode  = 1'b0;
    btn_start = 1'b1;
    btn_stop  = 1'b1;
    step(7);
    chk("pri_pre", 32'(st), 32'(ST_RUN));
    step(1);
    chk("pri_idle", 32'(st), 32'(ST_IDLE));
    chk("pri_sec", 32'(sec_left), 32'd0);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    step(10);

    btn_mode = 1'b1;
    step(8);
    chk("mode_hi", 32'(mode), 32'd3);
    btn_mode = 1'b0;
    step(10);

    // Restart from DONE, then reset mid-run
    btn_start = 1'b1;
    step(8);
    btn_start = 1'b0;
    step(35);
    chk("rs_done", 32'(st), 32'(ST_DONE));
    btn_start = 1'b1;
    step(7);
    chk("rs_pre", 32'(st), 32'(ST_DONE));
    step(1);
    chk("rs_clr", 32'(st), 32'(ST_CLEAR));
    btn_start = 1'b0;
    step(5);
    chk("rs_run", 32'(sec_left), 32'd3);
    step(10);
    chk("rs_s2", 32'(sec_left), 32'd2);
    sys_rst = 1'b1;
    step(1);
    chk("mr_rst_st", 32'(st), 32'(ST_IDLE));
    chk("mr_rst_mode", 32'(mode), 32'd2);
    chk("mr_rst_sec", 32'(sec_left), 32'd0);
    sys_rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/led_session_controller.md
# led_session_controller

Front-end control FSM that drives the mode/start/idle/mini_rst inputs of the LED pattern engine from three raw push-buttons. It debounces the buttons, lets the user cycle the speed mode while idle, sequences a counter clear, runs a timed LED session, and returns to idle on timeout or stop. It sits between the board buttons and the LED pattern top on the same system clock.

## Interface

Parameters:
- DB_CYCLES, 1_000_000: consecutive stable cycles required before a debounced level changes.
- TICK_DIV, 100_000_000: sys_clk cycles per one-second tick.
- RUN_SECS, 30: session length in seconds, range 1..255.
- DONE_SECS, 3: post-session hold in seconds, range 1..255.
- CLR_CYCLES, 4_194_304: mini_rst assertion length in cycles. 2^22 covers one period of the slowest LED clock.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_stop  in  1  raw stop button, asynchronous, active-high.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- mode  out  2  LED speed mode: 2'b01 low, 2'b10 normal, 2'b11 high. Never 2'b00.
- start  out  1  LED pattern run enable.
- idle  out  1  LED idle-pattern select.
- mini_rst  out  1  clear for the LED step counter.
- busy  out  1  high in CLEAR, RUN and DONE.
- sec_left  out  8  seconds remaining in RUN; 0 otherwise.

## Operation

- **Button path:**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level flips only after the synchronized level has differed from it for DB_CYCLES consecutive cycles. Any agreeing cycle restarts the count.
  - A press event is a 1-cycle pulse on the debounced rising edge. Release generates nothing.
- **Mode:**
  - Reset value 2'b10.
  - A mode event in IDLE advances 01→10→11→01.
  - Mode events in any other state are dropped.
- **States:** IDLE, CLEAR, RUN, DONE. Outputs are a Moore decode of the state register.
  - IDLE: idle=1, start=0, mini_rst=0, busy=0.
    - start event → CLEAR.
    - stop event ignored.
  - CLEAR: idle=0, start=0, mini_rst=1, busy=1.
    - Stays exactly CLR_CYCLES cycles, then → RUN.
    - stop event → IDLE.
  - RUN: idle=0, start=1, mini_rst=0, busy=1.
    - Tick counter and sec_left are loaded on entry (sec_left=RUN_SECS).
    - Each tick decrements sec_left. The tick that brings it to 0 moves to DONE.
    - stop event → IDLE.
    - start event ignored.
  - DONE: idle=0, start=0, mini_rst=0, busy=1.
    - Holds DONE_SECS ticks, then → IDLE.
    - start event → CLEAR (restart).
    - stop event → IDLE.
- **Simultaneous events:** stop beats start. A mode event in the same cycle as start in IDLE is applied and the transition is still taken.
- **Tick counter:**
  - Width is ceil(log2(TICK_DIV)).
  - Counts 0..TICK_DIV-1 and wraps; the tick is the wrap cycle.
  - Cleared on entry to RUN and DONE; held at 0 in IDLE and CLEAR.
- **Reset:**
  - State IDLE, mode=2'b10, start=0, idle=1, mini_rst=0, busy=0, sec_left=0.
  - Synchronizers, debounced levels and all counters are cleared to 0.
  - Reset mid-session drops immediately to IDLE values on the next edge.

## Timing

- Raw press (clean edge) to press event: 2 sync cycles + DB_CYCLES + 1 cycle.
- Press event to state change: 1 cycle. Outputs change in the same cycle as the state register.
- CLEAR duration: exactly CLR_CYCLES cycles with mini_rst high.
- RUN duration with no stop: RUN_SECS × TICK_DIV cycles.
- DONE duration: DONE_SECS × TICK_DIV cycles.
- sec_left changes only on tick cycles while in RUN; 0 in the cycle RUN is exited.

## Test plan

All scenarios use DB_CYCLES=4, TICK_DIV=10, RUN_SECS=3, DONE_SECS=2, CLR_CYCLES=5.

- **Reset/defaults:** assert sys_rst 3 cycles → mode=2'b10, idle=1, start=0, mini_rst=0, busy=0, sec_left=0.
- **Bounce rejection:** btn_start toggling every 2 cycles for 20 cycles, then held high → exactly one start event, 7 cycles after the stable high begins; state IDLE→CLEAR once.
- **Full session:** clean start press → mini_rst high exactly 5 cycles, then start=1 with sec_left 3,2,1 stepping every 10 cycles. After 30 RUN cycles: DONE with start=0, idle=0; 20 cycles later back to IDLE with idle=1.
- **Mode cycling:** three mode presses in IDLE → 2'b11, 2'b01, 2'b10. A mode press during RUN leaves mode unchanged.
- **Stop/priority:** start and stop press events in the same cycle during RUN → IDLE next cycle. Stop during CLEAR → mini_rst drops, IDLE.
- **Restart/reset mid-run:** start press in DONE → CLEAR. sys_rst asserted at sec_left=2 → all outputs at reset values on the next edge.
